// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the ram_sp_init storage block.
package ram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_sp_init_if.sv
// ram_sp_init_if: request/response bundle between a datapath master and ram_sp_init.
interface ram_sp_init_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    localparam int BE_W = DATA_W / 8;

    logic              clr;
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   be;
    logic              ready;
    logic              busy;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              par_err;

    modport master (
        output clr, req, wr, addr, wr_data, be,
        input  ready, busy, rd_valid, rd_data, par_err
    );

    modport slave (
        input  clr, req, wr, addr, wr_data, be,
        output ready, busy, rd_valid, rd_data, par_err
    );

endinterface

// File: rtl/ram_parity_gen.sv
// ram_parity_gen: combinational even-parity bit per byte of a data word.
module ram_parity_gen
    import ram_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]        data,
    output logic [DATA_W/BYTE_W-1:0] par
);
    localparam int BE_W = DATA_W / BYTE_W;

    for (genvar i = 0; i < BE_W; i++) begin : g_byte
        assign par[i] = ^data[i*BYTE_W +: BYTE_W];
    end

endmodule

// File: rtl/ram_sp_init.sv
// ram_sp_init: single-port RAM, byte enables, 1-cycle registered read, zero-fill after reset/clr.
// Define RAM_PARITY_EN to store per-byte even parity and flag mismatches on read.
module ram_sp_init
    import ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    ram_sp_init_if.slave bus
);
    localparam int BE_W  = DATA_W / BYTE_W;
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [0:0] S_INIT = ST_INIT;
    localparam logic [0:0] S_IDLE = ST_IDLE;

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              acc, wr_acc, rd_acc;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    // clr takes priority over a request presented in the same cycle
    assign bus.ready    = (state == S_IDLE) && !bus.clr;
    assign bus.busy     = (state == S_INIT);
    assign acc          = bus.req && bus.ready;
    assign wr_acc       = acc && bus.wr;
    assign rd_acc       = acc && !bus.wr;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            state <= S_INIT;
            ptr   <= '0;
        end else if (state == S_INIT) begin
            if (ptr == PTR_LAST)
                state <= S_IDLE;
            else
                ptr <= ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_INIT) begin
                mem[ptr] <= '0;
            end else if (wr_acc) begin
                for (int i = 0; i < BE_W; i++)
                    if (bus.be[i])
                        mem[bus.addr][i*BYTE_W +: BYTE_W] <= bus.wr_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc)
                rd_data_q <= mem[bus.addr];
        end
    end

`ifdef RAM_PARITY_EN
    logic [BE_W-1:0] par_mem [DEPTH];
    logic [BE_W-1:0] wr_par, rd_par, par_q;

    ram_parity_gen #(.DATA_W(DATA_W)) u_wr_par (.data(bus.wr_data), .par(wr_par));
    ram_parity_gen #(.DATA_W(DATA_W)) u_rd_par (.data(rd_data_q),   .par(rd_par));

    // a zero byte has even parity 0, so fill clears parity alongside data
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_INIT) begin
                par_mem[ptr] <= '0;
            end else if (wr_acc) begin
                for (int i = 0; i < BE_W; i++)
                    if (bus.be[i])
                        par_mem[bus.addr][i] <= wr_par[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            par_q <= '0;
        else if (rd_acc)
            par_q <= par_mem[bus.addr];
    end

    assign bus.par_err = rd_valid_q && (rd_par != par_q);
`else
    assign bus.par_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sp_init.sv
// tb_ram_sp_init: randomized scoreboard bench for ram_sp_init (DATA_W=32, ADDR_W=3).
module tb_ram_sp_init;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int DEPTH = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          par;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] model [DEPTH];
    exp_t          q [$];

    ram_sp_init_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ram_sp_init #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // scoreboard monitor: every rd_valid pulse must match the oldest outstanding read
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_valid: got 1 expected 0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rd_latency", DW'(cyc), DW'(e.due));
                chk("rd_data", bus.rd_data, e.data);
                chk("par_err", DW'(bus.par_err), DW'(e.par));
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [3:0] b, input logic exp_par);
        logic acc;
        exp_t e;
        @(negedge clk);
        bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.wr_data = d; bus.be = b;
        #1 acc = bus.ready;
        e.due = cyc + 1;
        @(posedge clk);
        if (acc) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
            end else begin
                e.data = model[a];
                e.par  = exp_par;
                q.push_back(e);
            end
        end
        #1 bus.req = 1'b0;
    endtask

    // call in cycle 0 of a fill; counts cycles until ready, bounded
    task automatic wait_fill(input string name);
        int  n = 0;
        logic busy_ok = 1'b1;
        while (bus.ready !== 1'b1 && n < 50) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            n++;
            @(negedge clk);
            #1;
        end
        chk({name, "_len"}, DW'(n), DW'(8));
        chk({name, "_busy"}, DW'(busy_ok), DW'(1));
        chk({name, "_busy_done"}, DW'(bus.busy), DW'(0));
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", DW'(q.size()), DW'(0));
    endtask

    initial begin
        bus.clr = 1'b0; bus.req = 1'b0; bus.wr = 1'b0;
        bus.addr = '0; bus.wr_data = '0; bus.be = '0;
        model_clear();

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", DW'(bus.ready), DW'(0));
        chk("rst_busy", DW'(bus.busy), DW'(1));
        chk("rst_rd_valid", DW'(bus.rd_valid), DW'(0));
        chk("rst_rd_data", bus.rd_data, '0);
        chk("rst_par_err", DW'(bus.par_err), DW'(0));
        rst = 1'b0;
        #1 wait_fill("fill_after_rst");

        // directed reads/writes
        op(1'b0, 3'd5, '0, 4'h0, 1'b0);
        op(1'b1, 3'd0, 32'h0000_00CC, 4'h1, 1'b0);
        op(1'b0, 3'd0, '0, 4'h0, 1'b0);
        op(1'b0, 3'd1, '0, 4'h0, 1'b0);
        op(1'b1, 3'd2, 32'hAABB_CCDD, 4'hF, 1'b0);
        op(1'b1, 3'd2, 32'h1122_3344, 4'h5, 1'b0);
        op(1'b1, 3'd2, 32'hDEAD_BEEF, 4'h0, 1'b0);
        op(1'b0, 3'd2, '0, 4'h0, 1'b0);
        drain();
        chk("byte_merge_model", model[2], 32'hAA22_CC44);

        // randomized traffic
        for (int i = 0; i < 300; i++)
            op(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)), $urandom(),
               4'($urandom_range(0, 15)), 1'b0);
        drain();

        // clr in IDLE together with a write: write refused, array zeroed
        @(negedge clk);
        bus.clr = 1'b1; bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 3'd3;
        bus.wr_data = 32'hFFFF_FFFF; bus.be = 4'hF;
        #1 chk("clr_ready", DW'(bus.ready), DW'(0));
        @(posedge clk);
        #1 bus.clr = 1'b0; bus.req = 1'b0;
        chk("clr_busy", DW'(bus.busy), DW'(1));
        model_clear();
        @(negedge clk);
        #1 wait_fill("fill_after_clr");
        for (int a = 0; a < DEPTH; a++) op(1'b0, AW'(a), '0, 4'h0, 1'b0);
        drain();

        // rst together with a read: no rd_valid must follow
        for (int a = 0; a < DEPTH; a++) op(1'b1, AW'(a), $urandom(), 4'hF, 1'b0);
        @(negedge clk);
        rst = 1'b1; bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 3'd2;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        chk("rst_read_suppressed", DW'(bus.rd_valid), DW'(0));
        rst = 1'b0;
        model_clear();
        // rst again when the fill pointer has reached 4
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_midfill_busy", DW'(bus.busy), DW'(1));
        chk("rst_midfill_rd_valid", DW'(bus.rd_valid), DW'(0));
        rst = 1'b0;
        #1 wait_fill("fill_restart");
        for (int a = 0; a < DEPTH; a++) op(1'b0, AW'(a), '0, 4'h0, 1'b0);
        drain();

`ifdef RAM_PARITY_EN
        op(1'b1, 3'd6, 32'h1357_9BDF, 4'hF, 1'b0);
        op(1'b1, 3'd6, 32'h0F0F_0F0F, 4'h6, 1'b0);
        op(1'b0, 3'd6, '0, 4'h0, 1'b0);
        drain();
        @(negedge clk);
        dut.par_mem[6][0] = ~dut.par_mem[6][0];
        op(1'b0, 3'd6, '0, 4'h0, 1'b1);
        op(1'b1, 3'd6, model[6], 4'hF, 1'b0);
        op(1'b0, 3'd6, '0, 4'h0, 1'b0);
        drain();
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_sp_init.md
# ram_sp_init

Parametrised single-port synchronous RAM with per-byte write enables, registered one-cycle read, and a hardware initialisation sequencer that zeroes every word after reset or on request. It is the general-purpose storage block for datapaths in this codebase and replaces fixed 8×8 storage with a sized, handshaked array. An optional per-byte parity check flags corrupted read data.

## Interface
- DATA_W, 8, word width in bits; must be a multiple of 8
- ADDR_W, 3, address width; depth is 2**ADDR_W words
- BE_W, DATA_W/8, byte-enable width (localparam, derived)

- clk  in  1  rising-edge clock, the block's only clock
- rst  in  1  synchronous, active-high reset
- clr  in  1  one-cycle pulse: re-run the zero-fill sequence
- req  in  1  access request, qualified by ready
- wr  in  1  1 = write, 0 = read; sampled with req
- addr  in  ADDR_W  word address
- wr_data  in  DATA_W  write data
- be  in  BE_W  byte enables; bit i gates wr_data[8i+7:8i]
- ready  out  1  block can accept req this cycle
- busy  out  1  zero-fill in progress
- rd_valid  out  1  rd_data valid (single-cycle pulse)
- rd_data  out  DATA_W  read data
- par_err  out  1  parity mismatch on current read

## Operation
- States: INIT, IDLE. rst forces INIT with fill pointer = 0.
- INIT: write 0 (and correct parity) to word[ptr] each cycle, ptr++; at ptr = 2**ADDR_W-1 write it and go to IDLE next cycle. busy=1, ready=0.
- IDLE: busy=0; ready = !clr. clr=1 in IDLE → INIT, ptr=0; a req in that same cycle is not accepted (clr priority).
- clr in INIT: restarts fill at ptr=0.
- Accepted write (req&ready&wr): bytes with be[i]=1 updated at that clock edge; others unchanged; be=0 is a legal no-op.
- Accepted read (req&ready&!wr): next cycle rd_valid=1, rd_data=word[addr]. rd_data holds its value until the next read completes; rd_valid is 0 otherwise.
- Back-to-back accepted accesses every cycle allowed; write to X then read of X on next cycle returns new data.
- be ignored for reads.

## Timing
- Reset values: ready=0, busy=1, rd_valid=0, rd_data=0, par_err=0. Array contents are not reset directly; the fill sequence clears them.
- Fill length: exactly 2**ADDR_W cycles after rst deasserts; ready first high on cycle 2**ADDR_W (counting first non-reset cycle as 0).
- Read latency: 1 cycle, address to rd_data.
- Write latency: 0 (visible to a read accepted the next cycle).
- rst mid-read: pending rd_valid suppressed; rst mid-fill: fill restarts.
- Pointer wrap: ptr is ADDR_W bits; terminal compare, no wrap into a second pass.

## Configuration
- RAM_PARITY_EN defined: one parity bit (even parity) stored per byte, written alongside each enabled byte and during fill; on every read, recomputed per byte; par_err=1 in the rd_valid cycle if any byte mismatches, else 0.
- Undefined: no parity storage; par_err tied to 0. Port list identical in both builds.

## Structure
- Package ram_pkg: state enum (ST_INIT, ST_IDLE), helper constant BYTE_W=8.
- Sub-module ram_parity_gen: combinational per-byte even-parity generator (DATA_W in, BE_W out), instantiated twice (write path, read check) only under RAM_PARITY_EN.
- Array, fill counter and FSM in the top module.

## Test plan
- rst high 2 cycles, release → busy=1 for 8 cycles, ready rises on cycle 8; read addr 5 → rd_data=0x00, rd_valid one cycle later.
- Write addr 0 = 0xCC (be=1), then read addr 0 next cycle → rd_data=0xCC; read addr 1 → 0x00.
- DATA_W=32: write 0xAABBCCDD be=4'hF, then 0x11223344 be=4'b0101 → read returns 0xAA22CC44.
- clr pulse in IDLE together with req write → write not accepted, busy=1 next cycle, after 8 cycles all words read 0.
- rst asserted during fill at ptr=4 and during a pending read → rd_valid stays 0, fill restarts at 0 and completes 8 cycles after release.
- With RAM_PARITY_EN: reads after fill and after partial-byte writes → par_err=0 throughout; force one stored parity bit in simulation → par_err=1 with that read's rd_valid.
